// File: rtl/sign_accumulate_lenet.sv
`timescale 1ns/1ps
// sign_accumulate_lenet
//   Sign-weighted dot-product accumulator for binarised-weight LeNet layers.
//   Sign words (one bit per lane, 1 = negative) are queued in a 4-entry FIFO
//   and paired with product beats in arrival order. Each beat is reduced to a
//   signed lane sum (stage 1). The sums are accumulated over REPEAT_LENGTH
//   beats (stage 2), and the row total is narrowed onto result_out.
//
//   Optional build macro: SIGN_ACC_SATURATE_EN
//     defined   -> accumulator-to-output narrowing saturates
//     undefined -> narrowing keeps the low OUT_BITWIDTH bits (wraps)
//
// Ports
//   clk               rising-edge clock
//   rst               synchronous active-high reset
//   layer             one-hot layer select, latched at integration_start
//   integration_start one-cycle pulse that starts a layer
//   sign_in/valid     sign word and its qualifier (FIFO push)
//   product_in/valid  packed unsigned lane products and qualifier (FIFO pop)
//   result_out        signed row result, held between result_valid pulses
//   result_valid      one-cycle pulse per completed row
//   row_index         row number belonging to result_out
//   layer_done        pulses together with the final row of the layer
//   align_error       sticky FIFO overflow/underflow flag
module sign_accumulate_lenet #(
  parameter int unsigned WEIGHT_SIGN_BITWIDTH  = 16,
  parameter int unsigned PRODUCT_BITWIDTH      = 8,
  parameter int unsigned ACC_BITWIDTH          = 24,
  parameter int unsigned OUT_BITWIDTH          = 16,
  parameter int unsigned LAYER_1_REPEAT_LENGTH = 49,
  parameter int unsigned LAYER_2_REPEAT_LENGTH = 19,
  parameter int unsigned LAYER_3_REPEAT_LENGTH = 7,
  parameter int unsigned LAYER_1_ROWS          = 300,
  parameter int unsigned LAYER_2_ROWS          = 100,
  parameter int unsigned LAYER_3_ROWS          = 10
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [2:0]                                   layer,
  input  logic                                         integration_start,
  input  logic [WEIGHT_SIGN_BITWIDTH-1:0]              sign_in,
  input  logic                                         sign_valid,
  input  logic [WEIGHT_SIGN_BITWIDTH*PRODUCT_BITWIDTH-1:0] product_in,
  input  logic                                         product_valid,
  output logic [OUT_BITWIDTH-1:0]                      result_out,
  output logic                                         result_valid,
  output logic [8:0]                                   row_index,
  output logic                                         layer_done,
  output logic                                         align_error
);

  localparam int unsigned NL = WEIGHT_SIGN_BITWIDTH;

  localparam logic [15:0] L1_REP  = 16'(LAYER_1_REPEAT_LENGTH);
  localparam logic [15:0] L2_REP  = 16'(LAYER_2_REPEAT_LENGTH);
  localparam logic [15:0] L3_REP  = 16'(LAYER_3_REPEAT_LENGTH);
  localparam logic [8:0]  L1_ROWS = 9'(LAYER_1_ROWS);
  localparam logic [8:0]  L2_ROWS = 9'(LAYER_2_ROWS);
  localparam logic [8:0]  L3_ROWS = 9'(LAYER_3_ROWS);

  typedef enum logic {S_IDLE, S_ACCUM} state_e;

  state_e state_q, state_d;
  logic   accept_en;

  // Layer configuration
  logic [2:0]  layer_q;
  logic [15:0] rep_len;
  logic [8:0]  row_total;
  logic        layer_onehot;

  // Sign FIFO
  logic [NL-1:0] fifo_q [4];
  logic [1:0]    wr_ptr_q, rd_ptr_q;
  logic [2:0]    count_q, count_d;
  logic          fifo_empty, fifo_full;
  logic          push_req, pop_req, do_push, do_pop;
  logic          overflow, underflow, beat_acc;
  logic [NL-1:0] beat_sign;

  // Beat/row bookkeeping
  logic [15:0] beat_cnt_q;
  logic [8:0]  row_cnt_q;
  logic        last_beat, last_row;

  // Stage 1: signed lane reduction
  logic signed [ACC_BITWIDTH-1:0] lane_sum, lane_mag;
  logic signed [ACC_BITWIDTH-1:0] s1_sum_q;
  logic                           s1_valid_q, s1_last_q, s1_done_q;
  logic [8:0]                     s1_row_q;

  // Stage 2: row accumulation
  logic signed [ACC_BITWIDTH-1:0] acc_q, fin_q;
  logic                           fin_valid_q, fin_done_q;
  logic [8:0]                     fin_row_q;
  logic [OUT_BITWIDTH-1:0]        narrowed;

  // Output registers
  logic [OUT_BITWIDTH-1:0] result_out_q;
  logic                    result_valid_q, layer_done_q, align_error_q;
  logic [8:0]              row_index_q;

  assign layer_onehot = (layer == 3'b001) || (layer == 3'b010) || (layer == 3'b100);

  always_comb begin
    case (layer_q)
      3'b010:  begin rep_len = L2_REP; row_total = L2_ROWS; end
      3'b100:  begin rep_len = L3_REP; row_total = L3_ROWS; end
      default: begin rep_len = L1_REP; row_total = L1_ROWS; end
    endcase
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    if (integration_start)
      state_d = layer_onehot ? S_ACCUM : S_IDLE;
    else if (state_q == S_ACCUM && beat_acc && last_beat && last_row)
      state_d = S_IDLE;
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    accept_en = (state_q == S_ACCUM);
  end

  // FIFO control. A push and pop together on an empty FIFO bypasses the
  // storage; on a full FIFO the head is read while the same slot is rewritten.
  assign fifo_empty = (count_q == 3'd0);
  assign fifo_full  = (count_q == 3'd4);
  assign push_req   = sign_valid && !integration_start;
  assign pop_req    = product_valid && accept_en && !integration_start;
  assign do_push    = push_req && (!fifo_full || pop_req) && !(fifo_empty && pop_req);
  assign do_pop     = pop_req && !fifo_empty;
  assign overflow   = push_req && fifo_full && !pop_req;
  assign underflow  = pop_req && fifo_empty && !push_req;
  assign beat_acc   = pop_req && (!fifo_empty || push_req);
  assign beat_sign  = fifo_empty ? sign_in : fifo_q[rd_ptr_q];
  assign count_d    = count_q + 3'(do_push) - 3'(do_pop);

  assign last_beat  = (beat_cnt_q == rep_len - 16'd1);
  assign last_row   = (row_cnt_q == row_total - 9'd1);

  always_comb begin
    lane_sum = '0;
    lane_mag = '0;
    for (int unsigned i = 0; i < NL; i++) begin
      lane_mag = ACC_BITWIDTH'(product_in[PRODUCT_BITWIDTH*i +: PRODUCT_BITWIDTH]);
      if (beat_sign[i]) lane_sum = lane_sum - lane_mag;
      else              lane_sum = lane_sum + lane_mag;
    end
  end

`ifdef SIGN_ACC_SATURATE_EN
  localparam logic signed [ACC_BITWIDTH-1:0] OUT_MAX =
    {{(ACC_BITWIDTH-OUT_BITWIDTH+1){1'b0}}, {(OUT_BITWIDTH-1){1'b1}}};
  localparam logic signed [ACC_BITWIDTH-1:0] OUT_MIN =
    {{(ACC_BITWIDTH-OUT_BITWIDTH+1){1'b1}}, {(OUT_BITWIDTH-1){1'b0}}};

  always_comb begin
    if (fin_q > OUT_MAX)      narrowed = OUT_MAX[OUT_BITWIDTH-1:0];
    else if (fin_q < OUT_MIN) narrowed = OUT_MIN[OUT_BITWIDTH-1:0];
    else                      narrowed = fin_q[OUT_BITWIDTH-1:0];
  end
`else
  logic unused_fin_hi;
  assign unused_fin_hi = ^fin_q[ACC_BITWIDTH-1:OUT_BITWIDTH];
  assign narrowed      = fin_q[OUT_BITWIDTH-1:0];
`endif

  // FIFO storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (!rst && !integration_start && do_push)
      fifo_q[wr_ptr_q] <= sign_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      layer_q        <= 3'b001;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      beat_cnt_q     <= '0;
      row_cnt_q      <= '0;
      s1_valid_q     <= 1'b0;
      s1_sum_q       <= '0;
      s1_last_q      <= 1'b0;
      s1_done_q      <= 1'b0;
      s1_row_q       <= '0;
      acc_q          <= '0;
      fin_q          <= '0;
      fin_valid_q    <= 1'b0;
      fin_done_q     <= 1'b0;
      fin_row_q      <= '0;
      result_out_q   <= '0;
      result_valid_q <= 1'b0;
      row_index_q    <= '0;
      layer_done_q   <= 1'b0;
      align_error_q  <= 1'b0;
    end else if (integration_start) begin
      if (layer_onehot) layer_q <= layer;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      beat_cnt_q     <= '0;
      row_cnt_q      <= '0;
      s1_valid_q     <= 1'b0;
      acc_q          <= '0;
      fin_valid_q    <= 1'b0;
      result_valid_q <= 1'b0;
      layer_done_q   <= 1'b0;
      align_error_q  <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q <= count_d;
      if (overflow || underflow) align_error_q <= 1'b1;

      // Stage 1: row position travels with the beat so stage 2 needs no counters
      s1_valid_q <= beat_acc;
      if (beat_acc) begin
        s1_sum_q   <= lane_sum;
        s1_last_q  <= last_beat;
        s1_row_q   <= row_cnt_q;
        s1_done_q  <= last_beat && last_row;
        beat_cnt_q <= last_beat ? '0 : beat_cnt_q + 16'd1;
        if (last_beat) row_cnt_q <= last_row ? '0 : row_cnt_q + 9'd1;
      end

      // Stage 2
      fin_valid_q <= s1_valid_q && s1_last_q;
      if (s1_valid_q) begin
        if (s1_last_q) begin
          fin_q      <= acc_q + s1_sum_q;
          fin_row_q  <= s1_row_q;
          fin_done_q <= s1_done_q;
          acc_q      <= '0;
        end else begin
          acc_q <= acc_q + s1_sum_q;
        end
      end

      // Output
      result_valid_q <= fin_valid_q;
      layer_done_q   <= fin_valid_q && fin_done_q;
      if (fin_valid_q) begin
        result_out_q <= narrowed;
        row_index_q  <= fin_row_q;
      end
    end
  end

  assign result_out   = result_out_q;
  assign result_valid = result_valid_q;
  assign row_index    = row_index_q;
  assign layer_done   = layer_done_q;
  assign align_error  = align_error_q;

endmodule

// File: tb/tb_sign_accumulate_lenet.sv
`timescale 1ns/1ps
module tb_sign_accumulate_lenet;

  localparam int W  = 16;
  localparam int P  = 8;
  localparam int OW = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [2:0]     layer;
  logic           integration_start;
  logic [W-1:0]   sign_in;
  logic           sign_valid;
  logic [W*P-1:0] product_in;
  logic           product_valid;
  logic [OW-1:0]  result_out;
  logic           result_valid;
  logic [8:0]     row_index;
  logic           layer_done;
  logic           align_error;

  sign_accumulate_lenet #(
    .WEIGHT_SIGN_BITWIDTH (W),
    .PRODUCT_BITWIDTH     (P),
    .ACC_BITWIDTH         (24),
    .OUT_BITWIDTH         (OW),
    .LAYER_1_REPEAT_LENGTH(49),
    .LAYER_2_REPEAT_LENGTH(19),
    .LAYER_3_REPEAT_LENGTH(7),
    .LAYER_1_ROWS         (300),
    .LAYER_2_ROWS         (100),
    .LAYER_3_ROWS         (10)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .layer            (layer),
    .integration_start(integration_start),
    .sign_in          (sign_in),
    .sign_valid       (sign_valid),
    .product_in       (product_in),
    .product_valid    (product_valid),
    .result_out       (result_out),
    .result_valid     (result_valid),
    .row_index        (row_index),
    .layer_done       (layer_done),
    .align_error      (align_error)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] res;
    logic [8:0]    row;
    logic          done;
    int            due;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] sq[$];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_rv     = 0;

  longint m_acc;
  int     m_beat, m_row, m_rep, m_rows;
  bit     m_active;

  function automatic logic [OW-1:0] narrow(input longint v);
    logic [63:0] t;
    t = v;
`ifdef SIGN_ACC_SATURATE_EN
    if (v > 32767)       t = 64'd32767;
    else if (v < -32768) t = 64'hFFFF_FFFF_FFFF_8000;
`endif
    return t[OW-1:0];
  endfunction

  function automatic logic [W*P-1:0] rand_prod();
    logic [W*P-1:0] r;
    for (int i = 0; i < W*P/32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // One clock; outputs sampled 1ns after the edge and results scoreboarded.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (result_valid) begin
      n_rv++;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_result: got result_valid=1 row=%0d res=%0d, required no result", row_index, result_out);
      end else begin
        e = exp_q.pop_front();
        if (result_out !== e.res || row_index !== e.row || layer_done !== e.done || cyc != e.due)
          $display("FAIL row_result: got res=%0d row=%0d done=%b cyc=%0d, required res=%0d row=%0d done=%b cyc=%0d",
                   result_out, row_index, layer_done, cyc, e.res, e.row, e.done, e.due);
        else
          n_pass++;
      end
    end
    while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      e = exp_q.pop_front();
      n_checks++;
      $display("FAIL missing_result: got no result_valid by cyc %0d, required row %0d res=%0d", e.due, e.row, e.res);
    end
  endtask

  task automatic model_beat(input logic [W-1:0] s, input logic [W*P-1:0] pw);
    exp_t   e;
    longint sum;
    logic [P-1:0] p;
    sum = 0;
    for (int i = 0; i < W; i++) begin
      p = pw[P*i +: P];
      if (s[i]) sum = sum - longint'(p);
      else      sum = sum + longint'(p);
    end
    m_acc += sum;
    m_beat++;
    if (m_beat == m_rep) begin
      e.res  = narrow(m_acc);
      e.row  = 9'(m_row);
      e.done = (m_row == m_rows - 1);
      e.due  = cyc + 3;
      exp_q.push_back(e);
      m_acc  = 0;
      m_beat = 0;
      if (m_row == m_rows - 1) m_active = 0;
      m_row++;
    end
  endtask

  task automatic drive(input logic sv, input logic [W-1:0] sw, input logic pv, input logic [W*P-1:0] pw);
    logic [W-1:0] s;
    sign_valid = sv; sign_in = sw; product_valid = pv; product_in = pw;
    if (sv) sq.push_back(sw);
    if (pv && m_active && sq.size() > 0) begin
      s = sq.pop_front();
      model_beat(s, pw);
    end
    tick();
    sign_valid = 1'b0; product_valid = 1'b0;
  endtask

  task automatic start(input logic [2:0] l);
    exp_q.delete(); sq.delete();
    m_acc = 0; m_beat = 0; m_row = 0; m_active = 1;
    case (l)
      3'b001:  begin m_rep = 49; m_rows = 300; end
      3'b010:  begin m_rep = 19; m_rows = 100; end
      3'b100:  begin m_rep = 7;  m_rows = 10;  end
      default: m_active = 0;
    endcase
    layer = l; integration_start = 1'b1;
    sign_valid = 1'b0; product_valid = 1'b0;
    tick();
    integration_start = 1'b0;
  endtask

  task automatic do_reset();
    exp_q.delete(); sq.delete(); m_active = 0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    n_checks++;
    if (result_out !== '0 || result_valid !== 1'b0 || row_index !== '0 || layer_done !== 1'b0 || align_error !== 1'b0)
      $display("FAIL %s: got res=%0d rv=%b row=%0d done=%b err=%b, required all 0",
               tag, result_out, result_valid, row_index, layer_done, align_error);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; layer = 3'b001; integration_start = 1'b0;
    sign_in = '0; sign_valid = 1'b0; product_in = '0; product_valid = 1'b0;
    m_active = 0;
    do_reset();
    check_outputs_zero("reset_state");
  endtask

  task automatic test_basic();
    start(3'b100);
    for (int b = 0; b < 7; b++) drive(1'b1, '0, 1'b1, {W{8'd10}});
    repeat (5) tick();
    n_checks++;
    if (result_out !== 16'd1120 || row_index !== 9'd0)
      $display("FAIL basic_hold: got res=%0d row=%0d, required res=1120 row=0", result_out, row_index);
    else n_pass++;
  endtask

  task automatic test_signs();
    int rv0;
    start(3'b100);
    rv0 = n_rv;
    for (int b = 0; b < 70; b++) drive(1'b1, 16'h00FF, 1'b1, {W{8'd1}});
    repeat (4) tick();
    n_checks++;
    if (n_rv - rv0 != 10) $display("FAIL signs_row_count: got %0d results, required 10", n_rv - rv0);
    else n_pass++;
    // Layer finished: further products are ignored without an error.
    for (int b = 0; b < 3; b++) drive(1'b0, '0, 1'b1, {W{8'd1}});
    repeat (3) tick();
    n_checks++;
    if (align_error !== 1'b0) $display("FAIL idle_ignore: got align_error=%b, required 0", align_error);
    else n_pass++;
  endtask

  task automatic test_saturate();
    logic [OW-1:0] req;
`ifdef SIGN_ACC_SATURATE_EN
    req = 16'd32767;
`else
    req = 16'h0CF0;
`endif
    start(3'b001);
    for (int b = 0; b < 49; b++) drive(1'b1, '0, 1'b1, {W{8'd255}});
    repeat (4) tick();
    n_checks++;
    if (result_out !== req || row_index !== 9'd0)
      $display("FAIL narrow_row0: got res=%h row=%0d, required res=%h row=0", result_out, row_index, req);
    else n_pass++;
    // Non-one-hot start returns to IDLE: products are not taken.
    start(3'b011);
    for (int b = 0; b < 3; b++) drive(1'b0, '0, 1'b1, {W{8'd255}});
    repeat (3) tick();
    n_checks++;
    if (align_error !== 1'b0) $display("FAIL bad_layer_idle: got align_error=%b, required 0", align_error);
    else n_pass++;
  endtask

  task automatic test_align();
    for (int k = 0; k < 4; k++) drive(1'b1, 16'(k), 1'b0, '0);
    n_checks++;
    if (align_error !== 1'b0) $display("FAIL fifo_four: got align_error=%b, required 0", align_error);
    else n_pass++;
    drive(1'b1, 16'h5, 1'b0, '0);
    n_checks++;
    if (align_error !== 1'b1) $display("FAIL fifo_overflow: got align_error=%b, required 1", align_error);
    else n_pass++;
    repeat (2) tick();
    n_checks++;
    if (align_error !== 1'b1) $display("FAIL err_sticky: got align_error=%b, required 1", align_error);
    else n_pass++;
    start(3'b010);
    n_checks++;
    if (align_error !== 1'b0) $display("FAIL err_clear: got align_error=%b, required 0", align_error);
    else n_pass++;
    m_active = 0;
    drive(1'b0, '0, 1'b1, {W{8'd3}});
    n_checks++;
    if (align_error !== 1'b1) $display("FAIL fifo_underflow: got align_error=%b, required 1", align_error);
    else n_pass++;
    start(3'b010);
  endtask

  task automatic test_rst_midrow();
    int rv0;
    start(3'b010);
    for (int b = 0; b < 10; b++) drive(1'b1, 16'($urandom), 1'b1, rand_prod());
    do_reset();
    repeat (5) tick();
    check_outputs_zero("rst_midrow");
    start(3'b010);
    rv0 = n_rv;
    for (int b = 0; b < 19; b++) drive(1'b1, 16'($urandom), 1'b1, rand_prod());
    repeat (4) tick();
    n_checks++;
    if (n_rv - rv0 != 1) $display("FAIL restart_row: got %0d results, required 1", n_rv - rv0);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int rv0;
    start(3'b010);
    rv0 = n_rv;
    for (int c = 0; c < 1903; c++)
      drive(c < 1900, 16'($urandom), c >= 3, rand_prod());
    repeat (4) tick();
    n_checks++;
    if (n_rv - rv0 != 100 || align_error !== 1'b0)
      $display("FAIL stream_layer2: got %0d results err=%b, required 100 results err=0", n_rv - rv0, align_error);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_saturate();
    test_align();
    test_rst_midrow();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
